// File: rtl/audio_rom_player.sv
`default_nettype none
// ============================================================================
//  Module   : audio_rom_player
//  Brief    : Plays an address window of a synchronous sample ROM at a fixed
//             sample rate (one-shot or loop), muting to IDLE_LEVEL when idle.
//  Revision : 1.0
// ============================================================================
module audio_rom_player #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int DIV        = 4,
    parameter int IDLE_LEVEL = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] audio_out,
    output logic              audio_valid,
    output logic              busy,
    output logic              done
);

    localparam int                 c_CNT_W    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(DIV - 1);
    localparam logic [DATA_W-1:0]  c_IDLE     = DATA_W'(IDLE_LEVEL);

    generate
        if (DIV < 2) begin : g_div_check
            $error("audio_rom_player: DIV must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [c_CNT_W-1:0]  r_div_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_start;
    logic [ADDR_W-1:0]   r_end;
    logic                r_loop;
    logic [DATA_W-1:0]   r_audio;
    logic                r_valid;
    logic                r_done;

    logic w_tick;
    logic w_start_go;
    logic w_stop_go;
    logic w_at_end;

    // start/stop bypass ena; only sample-rate progress is gated
    assign w_tick     = ((r_state == ST_PLAY) || (r_state == ST_DRAIN)) && ena
                        && (r_div_cnt == c_DIV_LAST);
    assign w_start_go = (r_state == ST_IDLE) && start && !stop;
    assign w_stop_go  = (r_state != ST_IDLE) && stop;
    assign w_at_end   = (r_addr == r_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_stop_go) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_start_go) w_next_state = ST_PRIME;
                ST_PRIME: w_next_state = ST_PLAY;
                ST_PLAY:  if (w_tick && w_at_end && !r_loop) w_next_state = ST_DRAIN;
                ST_DRAIN: if (w_tick) w_next_state = ST_IDLE;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_addr    <= '0;
            r_start   <= '0;
            r_end     <= '0;
            r_loop    <= 1'b0;
            r_audio   <= c_IDLE;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (w_stop_go) begin
                r_audio   <= c_IDLE;
                r_div_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start_go) begin
                            r_start <= start_addr;
                            r_end   <= end_addr;
                            r_loop  <= loop_en;
                            r_addr  <= start_addr;
                        end
                    end
                    // preload so the first enabled PLAY cycle is a tick
                    ST_PRIME: r_div_cnt <= c_DIV_LAST;
                    ST_PLAY, ST_DRAIN: begin
                        if (w_tick) begin
                            r_div_cnt <= '0;
                            if (r_state == ST_PLAY) begin
                                r_audio <= rom_data;
                                r_valid <= 1'b1;
                                if (!w_at_end) begin
                                    r_addr <= r_addr + ADDR_W'(1);
                                end else if (r_loop) begin
                                    r_addr <= r_start;
                                end
                            end else begin
                                r_audio <= c_IDLE;
                                r_done  <= 1'b1;
                            end
                        end else if (ena) begin
                            r_div_cnt <= r_div_cnt + c_CNT_W'(1);
                        end
                    end
                    default: r_div_cnt <= '0;
                endcase
            end
        end
    end

    assign rom_addr    = r_addr;
    assign audio_out   = r_audio;
    assign audio_valid = r_valid;
    assign done        = r_done;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_audio_rom_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_audio_rom_player
//  Brief    : Self-checking bench; sample scoreboard plus window vector table.
//  Revision : 1.0
// ============================================================================
module tb_audio_rom_player;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena, ena2;
    logic       start, start2, stop, loop_en;
    logic [7:0] start_addr, end_addr;

    logic [7:0] rom_addr1, rom_data1, audio1;
    logic       valid1, busy1, done1;
    logic [7:0] rom_addr2, rom_data2, audio2;
    logic       valid2, busy2, done2;

    always #5 clk = ~clk;

    audio_rom_player #(.DATA_W(8), .ADDR_W(8), .DIV(4), .IDLE_LEVEL(128)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .stop(stop),
        .loop_en(loop_en), .start_addr(start_addr), .end_addr(end_addr),
        .rom_addr(rom_addr1), .rom_data(rom_data1), .audio_out(audio1),
        .audio_valid(valid1), .busy(busy1), .done(done1)
    );

    audio_rom_player #(.DATA_W(8), .ADDR_W(8), .DIV(2), .IDLE_LEVEL(128)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena2), .start(start2), .stop(stop),
        .loop_en(loop_en), .start_addr(start_addr), .end_addr(end_addr),
        .rom_addr(rom_addr2), .rom_data(rom_data2), .audio_out(audio2),
        .audio_valid(valid2), .busy(busy2), .done(done2)
    );

    // ROM[a] = a, one-cycle read latency
    always @(posedge clk) begin
        rom_data1 <= rom_addr1;
        rom_data2 <= rom_addr2;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int q1[$];
    int q2[$];
    int last1 = -1;
    int last2 = -1;
    int dones1 = 0;
    int dones2 = 0;
    logic tog = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // scoreboard monitors: pop expected sample on every valid, check spacing
    always @(negedge clk) begin
        if (valid1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL valid1_unexpected: got sample 0x%0h expected none", audio1);
            end else begin
                chk("sample1", int'(audio1), q1.pop_front());
            end
            if (last1 >= 0) chk("period1", cyc - last1, 4);
            last1 = cyc;
        end
        if (done1) begin
            dones1++;
            chk("done_gap1", cyc - last1, 4);
        end
        if (valid2) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL valid2_unexpected: got sample 0x%0h expected none", audio2);
            end else begin
                chk("sample2", int'(audio2), q2.pop_front());
            end
            if (last2 >= 0) chk("period2", cyc - last2, 4);
            last2 = cyc;
        end
        if (done2) begin
            dones2++;
            chk("done_gap2", cyc - last2, 4);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (tog) ena2 = ~ena2;
    endtask

    task automatic wait_q(input int sel, input int n, input int budget, input string nm);
        int k = 0;
        while (((sel == 1) ? q1.size() : q2.size()) > n && k < budget) begin
            step();
            k++;
        end
        chk(nm, (sel == 1) ? q1.size() : q2.size(), n);
    endtask

    task automatic wait_idle(input int sel, input int budget, input string nm);
        int k = 0;
        while (((sel == 1) ? busy1 : busy2) && k < budget) begin
            step();
            k++;
        end
        chk(nm, int'((sel == 1) ? busy1 : busy2), 0);
    endtask

    typedef struct {
        logic [7:0] sa;
        logic [7:0] ea;
        logic       lp;
        int         n;
        int         exp_done;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int d0;
        int len;

        vecs[0] = '{sa: 8'h10, ea: 8'h13, lp: 1'b0, n: 4, exp_done: 1};
        vecs[1] = '{sa: 8'h20, ea: 8'h21, lp: 1'b1, n: 6, exp_done: 0};
        vecs[2] = '{sa: 8'hFE, ea: 8'h01, lp: 1'b0, n: 4, exp_done: 1};
        vecs[3] = '{sa: 8'h33, ea: 8'h33, lp: 1'b0, n: 1, exp_done: 1};

        rst_n = 1'b0; ena = 1'b1; ena2 = 1'b1;
        start = 1'b0; start2 = 1'b0; stop = 1'b0; loop_en = 1'b0;
        start_addr = 8'h00; end_addr = 8'h00;
        step();
        step();
        @(negedge clk);
        chk("reset_rom_addr", int'(rom_addr1), 0);
        chk("reset_audio", int'(audio1), 128);
        chk("reset_valid", int'(valid1), 0);
        chk("reset_busy", int'(busy1), 0);
        chk("reset_done", int'(done1), 0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 4; v++) begin
            len = ((int'(vecs[v].ea) - int'(vecs[v].sa)) & 255) + 1;
            for (int i = 0; i < vecs[v].n; i++)
                q1.push_back((int'(vecs[v].sa) + (i % len)) & 255);
            last1 = -1;
            d0 = dones1;
            start_addr = vecs[v].sa;
            end_addr   = vecs[v].ea;
            loop_en    = vecs[v].lp;
            start = 1'b1;
            step();
            start = 1'b0;
            wait_q(1, 0, 300, "vec_samples_drained");
            if (vecs[v].lp) begin
                stop = 1'b1;
                step();
                stop = 1'b0;
            end else begin
                wait_idle(1, 20, "vec_idle_timeout");
                step();
            end
            @(negedge clk);
            chk("vec_done_count", dones1 - d0, vecs[v].exp_done);
            chk("vec_audio_idle", int'(audio1), 128);
            chk("vec_busy", int'(busy1), 0);
        end

        // start and stop together from IDLE: nothing happens
        step();
        start_addr = 8'h77; end_addr = 8'h78; loop_en = 1'b0;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk("startstop_busy", int'(busy1), 0);
        chk("startstop_addr", int'(rom_addr1), 8'h33);

        // start while busy must not disturb the window
        step();
        last1 = -1;
        d0 = dones1;
        for (int i = 0; i < 3; i++) q1.push_back(8'h60 + i);
        start_addr = 8'h60; end_addr = 8'h62;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_q(1, 2, 50, "busy_first_sample");
        start_addr = 8'h90; end_addr = 8'h95;
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("busy_start_addr", int'(rom_addr1), 8'h61);
        chk("busy_start_busy", int'(busy1), 1);
        wait_q(1, 0, 50, "busy_samples_drained");
        wait_idle(1, 20, "busy_idle_timeout");
        step();
        chk("busy_done_count", dones1 - d0, 1);

        // stop mid-window: immediate mute, no done
        last1 = -1;
        d0 = dones1;
        for (int i = 0; i < 4; i++) q1.push_back(8'h70 + i);
        start_addr = 8'h70; end_addr = 8'h73;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_q(1, 2, 50, "stop_two_samples");
        stop = 1'b1;
        step();
        stop = 1'b0;
        @(negedge clk);
        chk("stop_audio", int'(audio1), 128);
        chk("stop_busy", int'(busy1), 0);
        q1.delete();
        for (int i = 0; i < 8; i++) step();
        chk("stop_no_done", dones1 - d0, 0);

        // DIV=2 instance with ena toggling every cycle
        last2 = -1;
        d0 = dones2;
        for (int i = 0; i < 4; i++) q2.push_back(8'h50 + i);
        start_addr = 8'h50; end_addr = 8'h53; loop_en = 1'b0;
        tog = 1'b1;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        wait_q(2, 0, 100, "ena_samples_drained");
        wait_idle(2, 20, "ena_idle_timeout");
        tog = 1'b0;
        ena2 = 1'b1;
        step();
        chk("ena_done_count", dones2 - d0, 1);
        chk("ena_audio_idle", int'(audio2), 128);

        // asynchronous reset mid-PLAY, then a fresh playback
        last1 = -1;
        for (int i = 0; i < 4; i++) q1.push_back(8'h40 + i);
        start_addr = 8'h40; end_addr = 8'h43;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_q(1, 2, 50, "rst_two_samples");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_audio", int'(audio1), 128);
        chk("arst_rom_addr", int'(rom_addr1), 0);
        chk("arst_busy", int'(busy1), 0);
        chk("arst_valid", int'(valid1), 0);
        q1.delete();
        step();
        rst_n = 1'b1;
        step();
        last1 = -1;
        d0 = dones1;
        q1.push_back(8'hA0);
        q1.push_back(8'hA1);
        start_addr = 8'hA0; end_addr = 8'hA1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_q(1, 0, 50, "replay_samples_drained");
        wait_idle(1, 20, "replay_idle_timeout");
        step();
        chk("replay_done_count", dones1 - d0, 1);
        chk("replay_audio_idle", int'(audio1), 128);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_rom_player.md
Name: audio_rom_player

Overview:
Parametrised successor to the free-running sample ROM driver. It plays a bounded address window [start_addr, end_addr] of an external synchronous sample ROM at a programmable sample rate, in either one-shot or loop mode. It handles the 1-cycle ROM read latency internally, mutes to a fixed idle level when not playing, and reports progress with valid/busy/done strobes. It sits between the sample ROM and the DAC/PWM stage.

Parameters:
DATA_W, 8, sample width in bits (ROM data and audio_out)
ADDR_W, 8, ROM address width
DIV, 4, clk cycles (with ena high) per output sample; must be >= 2, elaboration error otherwise
IDLE_LEVEL, 128, value driven on audio_out when muted (midscale for unsigned 8-bit)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  clock enable; low freezes all state except the stop/start handling below
start  in  1  1-cycle request to begin playback
stop  in  1  1-cycle request to abort playback
loop_en  in  1  sampled at start; 1 = loop window, 0 = one-shot
start_addr  in  ADDR_W  first sample address, latched at start
end_addr  in  ADDR_W  last sample address, latched at start
rom_addr  out  ADDR_W  address to sample ROM
rom_data  in  DATA_W  ROM output; reflects rom_addr from the previous clk edge
audio_out  out  DATA_W  current output sample (registered)
audio_valid  out  1  1-cycle pulse when audio_out takes a new ROM sample
busy  out  1  high in any state other than IDLE
done  out  1  1-cycle pulse at natural end of one-shot playback

Behaviour:
- Reset (async, rst_n=0): state IDLE, rom_addr=0, audio_out=IDLE_LEVEL, audio_valid=0, busy=0, done=0, div_cnt=0, latched window/loop=0.
- States: IDLE, PRIME, PLAY, DRAIN.
- IDLE: start=1 and stop=0 -> latch start_addr, end_addr, loop_en; rom_addr<=start_addr; go to PRIME. ena is not required for this transition.
- PRIME: lasts exactly 1 cycle while the ROM fetches. Then go to PLAY with div_cnt<=DIV-1, so the first tick falls on the first PLAY cycle with ena=1.
- tick = (state PLAY or DRAIN) and ena and div_cnt==DIV-1. On a tick div_cnt<=0; otherwise, when ena=1, div_cnt increments.
- PLAY tick:
  - audio_out<=rom_data; audio_valid=1 for that cycle.
  - If rom_addr!=end_addr: rom_addr<=rom_addr+1, modulo 2^ADDR_W (start_addr>end_addr wraps through the top of the ROM).
  - If rom_addr==end_addr and latched loop=1: rom_addr<=latched start_addr, stay in PLAY.
  - If rom_addr==end_addr and latched loop=0: go to DRAIN.
- DRAIN: holds the last sample for one full sample period. On the next tick: audio_out<=IDLE_LEVEL, done=1 for 1 cycle, audio_valid stays 0, go to IDLE.
- Sample period: exactly DIV ena-high cycles between consecutive audio_valid pulses. ena=0 stalls div_cnt, rom_addr, and state; audio_valid=0 while stalled.
- stop=1 in any non-IDLE state: next edge goes to IDLE with audio_out<=IDLE_LEVEL, no done pulse, div_cnt<=0. stop acts regardless of ena. stop in IDLE has no effect.
- start while busy is ignored. start and stop in the same cycle: stop wins.
- Window of one sample (start_addr==end_addr): one-shot gives 1 valid then done after one period; loop repeats the same sample indefinitely.
- rom_addr changes only at start, on a PLAY tick, or on reset.

Test Plan:
- DIV=4, window 0x10..0x13, one-shot, ROM[a]=a, ena=1: 4 valid pulses 4 cycles apart with audio_out 0x10,0x11,0x12,0x13; done exactly 4 cycles after the last valid; audio_out=128 afterwards; busy falls with done.
- Loop: window 0x20..0x21, loop_en=1, 6 ticks -> 0x20,0x21,0x20,0x21,0x20,0x21; done never asserts.
- Wrap: window 0xFE..0x01, one-shot -> samples 0xFE,0xFF,0x00,0x01, then done.
- ena toggled 1/0 every cycle with DIV=2: valid period becomes 4 clk cycles; sample sequence unchanged.
- stop pulsed mid-window: audio_out=128 and busy=0 on the next cycle, no done. start+stop in the same cycle from IDLE: stays IDLE. start while busy: no address change.
- rst_n asserted mid-PLAY, asynchronously between edges: outputs go to reset values immediately; a subsequent start replays from a fresh start_addr.
